// File: rtl/scoreboard.sv
// scoreboard: in-order issue/commit window. Holds issued instructions in a
// circular buffer, collects out-of-order FU writebacks by transaction ID,
// presents the oldest finished entry to commit and answers RAW queries.

package scoreboard_pkg;
   typedef enum logic [2:0] {
      FU_NONE   = 3'd0,
      FU_ALU    = 3'd1,
      FU_LSU    = 3'd2,
      FU_MULT   = 3'd3,
      FU_CSR    = 3'd4,
      FU_BRANCH = 3'd5
   } fu_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      fu_t         fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] result;
   } decoder_t;
endpackage

module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NR_ENTRIES  = 8,
   parameter int NR_WB_PORTS = 4,
   localparam int ID_W       = $clog2(NR_ENTRIES)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic                                  issue_valid,
   output logic                                  issue_ready,
   input  decoder_t                              issue_instr,
   output logic [ID_W-1:0]                       issue_id,
   input  logic [NR_WB_PORTS-1:0]                wb_valid,
   input  logic [NR_WB_PORTS-1:0][ID_W-1:0]      wb_id,
   input  logic [NR_WB_PORTS-1:0][31:0]          wb_result,
   output decoder_t                              commit_instr,
   input  logic                                  commit_ack,
   input  logic [1:0][4:0]                       rs_addr,
   output logic [1:0]                            rs_busy,
   output logic [1:0]                            rs_fwd_valid,
   output logic [1:0][31:0]                      rs_fwd_data,
   output logic                                  sb_empty
);

   localparam int CNT_W = ID_W + 1;

   // Pointers wrap naturally at ID_W bits; count disambiguates full vs empty.
   logic [ID_W-1:0]       r_head;
   logic [ID_W-1:0]       r_tail;
   logic [CNT_W-1:0]      r_count;
   logic [NR_ENTRIES-1:0] r_occ;
   logic [NR_ENTRIES-1:0] r_done;
   decoder_t              r_mem [NR_ENTRIES];

   logic                  w_enq;
   logic                  w_deq;
   decoder_t              w_enq_instr;
   logic [ID_W-1:0]       w_idx;

   // Issue handshake is independent of a same-cycle commit to keep the ready path short.
   always_comb begin
      issue_ready = (r_count != CNT_W'(NR_ENTRIES)) & ~flush;
      issue_id    = r_tail;
      sb_empty    = (r_count == '0);
      w_enq       = issue_valid & issue_ready;
      w_enq_instr        = issue_instr;
      w_enq_instr.valid  = 1'b0;
      w_enq_instr.result = '0;
   end

   // Head entry goes to commit once its result is in; no writeback bypass.
   always_comb begin
      commit_instr       = r_mem[r_head];
      commit_instr.valid = r_occ[r_head] & r_done[r_head];
      w_deq              = commit_ack & commit_instr.valid;
   end

   // Window state: flush acts as a synchronous reset and overrides everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_occ   <= '0;
         r_done  <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) r_mem[i] <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_occ   <= '0;
         r_done  <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) r_mem[i] <= '0;
      end else begin
         if (w_enq) begin
            r_mem[r_tail]  <= w_enq_instr;
            r_occ[r_tail]  <= 1'b1;
            r_done[r_tail] <= 1'b0;
            r_tail         <= r_tail + 1'b1;
         end
         // Ascending port order: the highest port targeting an ID wins.
         // Only already-occupied slots accept results, so a slot being
         // enqueued this cycle can never collide with a writeback.
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid[p] && r_occ[wb_id[p]]) begin
               r_done[wb_id[p]]       <= 1'b1;
               r_mem[wb_id[p]].result <= wb_result[p];
            end
         end
         // A full buffer blocks issue, so head and tail never alias here.
         if (w_deq) begin
            r_occ[r_head]  <= 1'b0;
            r_done[r_head] <= 1'b0;
            r_head         <= r_head + 1'b1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // RAW lookup walks oldest to youngest so the last match is the youngest producer.
   always_comb begin
      rs_busy      = '0;
      rs_fwd_valid = '0;
      rs_fwd_data  = '0;
      w_idx        = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            w_idx = r_head + ID_W'(i);
            if (r_occ[w_idx] && (rs_addr[k] != 5'd0) && (r_mem[w_idx].rd == rs_addr[k])) begin
               rs_busy[k]      = 1'b1;
               // CSR results are only architecturally valid at commit.
               rs_fwd_valid[k] = r_done[w_idx] && (r_mem[w_idx].fu != FU_CSR);
               rs_fwd_data[k]  = r_mem[w_idx].result;
            end
         end
      end
   end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: fill, out-of-order writeback, port priority,
// RAW forwarding, full-buffer commit/issue, pointer wrap, flush and async reset.

module tb_scoreboard;
   import scoreboard_pkg::*;

   localparam int N  = 8;
   localparam int WB = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic                 issue_valid;
   logic                 issue_ready;
   decoder_t             issue_instr;
   logic [2:0]           issue_id;
   logic [WB-1:0]        wb_valid;
   logic [WB-1:0][2:0]   wb_id;
   logic [WB-1:0][31:0]  wb_result;
   decoder_t             commit_instr;
   logic                 commit_ack;
   logic [1:0][4:0]      rs_addr;
   logic [1:0]           rs_busy;
   logic [1:0]           rs_fwd_valid;
   logic [1:0][31:0]     rs_fwd_data;
   logic                 sb_empty;

   int total = 0;
   int bad   = 0;

   scoreboard #(.NR_ENTRIES(N), .NR_WB_PORTS(WB)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_instr(issue_instr), .issue_id(issue_id),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_result(wb_result),
      .commit_instr(commit_instr), .commit_ack(commit_ack),
      .rs_addr(rs_addr), .rs_busy(rs_busy), .rs_fwd_valid(rs_fwd_valid),
      .rs_fwd_data(rs_fwd_data), .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; checks happen before the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Garbage valid/result fields must be cleared by the scoreboard on enqueue.
   function automatic decoder_t mk(input logic [4:0] rd, input fu_t fu);
      decoder_t d;
      d        = '0;
      d.valid  = 1'b1;
      d.pc     = {27'd0, rd} << 2;
      d.fu     = fu;
      d.op     = 8'h5A;
      d.rd     = rd;
      d.result = 32'hDEAD_BEEF;
      return d;
   endfunction

   task automatic clr_wb();
      wb_valid  = '0;
      wb_id     = '0;
      wb_result = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_instr = '0;
      commit_ack = 1'b0; rs_addr = '0; clr_wb();
      #12;
      rst = 1'b0;
      step();
      total++; if (commit_instr !== decoder_t'('0)) begin bad++; $display("FAIL reset_commit got=%h exp=0", commit_instr); end
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
      total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
      total++; if (issue_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", issue_id); end
      total++; if (rs_busy !== 2'b00 || rs_fwd_valid !== 2'b00) begin bad++; $display("FAIL reset_rs busy=%b fwd=%b exp=00/00", rs_busy, rs_fwd_valid); end
   endtask

   task automatic test_fill();
      for (int k = 0; k < N; k++) begin
         issue_valid = 1'b1;
         issue_instr = mk(5'(k + 1), FU_ALU);
         #1;
         total++; if (issue_id !== 3'(k) || issue_ready !== 1'b1) begin bad++; $display("FAIL fill_id[%0d] id=%0d rdy=%b exp id=%0d rdy=1", k, issue_id, issue_ready, k); end
         step();
      end
      issue_valid = 1'b0;
      #1;
      total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", issue_ready); end
      total++; if (commit_instr.valid !== 1'b0) begin bad++; $display("FAIL fill_commit_valid got=%b exp=0", commit_instr.valid); end
      total++; if (sb_empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", sb_empty); end
   endtask

   task automatic test_ooo_wb();
      logic [4:0]  exp_rd  [3];
      logic [31:0] exp_res [3];
      exp_rd  = '{5'd1, 5'd2, 5'd3};
      exp_res = '{32'h00, 32'h11, 32'h22};
      wb_valid[3] = 1'b1; wb_id[3] = 3'd2; wb_result[3] = 32'h22;
      step(); clr_wb();
      wb_valid[1] = 1'b1; wb_id[1] = 3'd1; wb_result[1] = 32'h11;
      step(); clr_wb();
      wb_valid[0] = 1'b1; wb_id[0] = 3'd0; wb_result[0] = 32'h00;
      #1;
      total++; if (commit_instr.valid !== 1'b0) begin bad++; $display("FAIL ooo_no_bypass got=%b exp=0", commit_instr.valid); end
      step(); clr_wb();
      commit_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (commit_instr.valid !== 1'b1 || commit_instr.rd !== exp_rd[k] || commit_instr.result !== exp_res[k])
            begin bad++; $display("FAIL ooo_commit[%0d] v=%b rd=%0d res=%h exp v=1 rd=%0d res=%h", k, commit_instr.valid, commit_instr.rd, commit_instr.result, exp_rd[k], exp_res[k]); end
         step();
      end
      commit_ack = 1'b0;
      #1;
      total++; if (commit_instr.valid !== 1'b0 || commit_instr.rd !== 5'd4) begin bad++; $display("FAIL ooo_head4 v=%b rd=%0d exp v=0 rd=4", commit_instr.valid, commit_instr.rd); end
   endtask

   task automatic test_wb_priority();
      // ID 4 holds rd=5; slot 0 is free at this point.
      wb_valid = 4'b0111;
      wb_id[0] = 3'd4; wb_result[0] = 32'hA;
      wb_id[1] = 3'd0; wb_result[1] = 32'hEE;
      wb_id[2] = 3'd4; wb_result[2] = 32'hB;
      step(); clr_wb();
      rs_addr[0] = 5'd5;
      #1;
      total++; if (rs_busy[0] !== 1'b1 || rs_fwd_valid[0] !== 1'b1 || rs_fwd_data[0] !== 32'hB)
         begin bad++; $display("FAIL prio_result busy=%b fv=%b d=%h exp 1/1/b", rs_busy[0], rs_fwd_valid[0], rs_fwd_data[0]); end
      issue_valid = 1'b1; issue_instr = mk(5'd20, FU_ALU);
      #1;
      total++; if (issue_id !== 3'd0) begin bad++; $display("FAIL tail_wrap id=%0d exp=0", issue_id); end
      step();
      issue_valid = 1'b0; rs_addr[1] = 5'd20;
      #1;
      total++; if (rs_busy[1] !== 1'b1 || rs_fwd_valid[1] !== 1'b0 || rs_fwd_data[1] !== 32'h0)
         begin bad++; $display("FAIL drop_free_wb busy=%b fv=%b d=%h exp 1/0/0", rs_busy[1], rs_fwd_valid[1], rs_fwd_data[1]); end
      rs_addr = '0;
   endtask

   task automatic test_raw();
      wb_valid[0] = 1'b1; wb_id[0] = 3'd4; wb_result[0] = 32'h55;
      step(); clr_wb();
      issue_valid = 1'b1; issue_instr = mk(5'd5, FU_ALU);
      #1;
      total++; if (issue_id !== 3'd1) begin bad++; $display("FAIL raw_id got=%0d exp=1", issue_id); end
      step();
      issue_valid = 1'b0; rs_addr[0] = 5'd5;
      #1;
      total++; if (rs_busy[0] !== 1'b1 || rs_fwd_valid[0] !== 1'b0 || rs_fwd_data[0] !== 32'h0)
         begin bad++; $display("FAIL raw_young_pending busy=%b fv=%b d=%h exp 1/0/0", rs_busy[0], rs_fwd_valid[0], rs_fwd_data[0]); end
      wb_valid[1] = 1'b1; wb_id[1] = 3'd1; wb_result[1] = 32'h66;
      #1;
      total++; if (rs_fwd_valid[0] !== 1'b0) begin bad++; $display("FAIL raw_same_cycle fv=%b exp=0", rs_fwd_valid[0]); end
      step(); clr_wb();
      #1;
      total++; if (rs_busy[0] !== 1'b1 || rs_fwd_valid[0] !== 1'b1 || rs_fwd_data[0] !== 32'h66)
         begin bad++; $display("FAIL raw_fwd busy=%b fv=%b d=%h exp 1/1/66", rs_busy[0], rs_fwd_valid[0], rs_fwd_data[0]); end
      rs_addr[0] = 5'd0;
      #1;
      total++; if (rs_busy[0] !== 1'b0 || rs_fwd_valid[0] !== 1'b0 || rs_fwd_data[0] !== 32'h0)
         begin bad++; $display("FAIL raw_x0 busy=%b fv=%b d=%h exp 0/0/0", rs_busy[0], rs_fwd_valid[0], rs_fwd_data[0]); end
      issue_valid = 1'b1; issue_instr = mk(5'd7, FU_CSR);
      step();
      issue_valid = 1'b0;
      wb_valid[2] = 1'b1; wb_id[2] = 3'd2; wb_result[2] = 32'h77;
      step(); clr_wb();
      rs_addr[0] = 5'd7;
      #1;
      total++; if (rs_busy[0] !== 1'b1 || rs_fwd_valid[0] !== 1'b0)
         begin bad++; $display("FAIL raw_csr busy=%b fv=%b exp 1/0", rs_busy[0], rs_fwd_valid[0]); end
      rs_addr = '0;
   endtask

   task automatic test_back_to_back();
      logic [4:0]  exp_rd  [7];
      logic [31:0] exp_res [7];
      exp_rd  = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd20, 5'd5, 5'd7};
      exp_res = '{32'h55, 32'h500, 32'h600, 32'h700, 32'h800, 32'h66, 32'h77};
      wb_valid[0] = 1'b1; wb_id[0] = 3'd3; wb_result[0] = 32'h44;
      step(); clr_wb();
      commit_ack = 1'b1; issue_valid = 1'b1; issue_instr = mk(5'd9, FU_ALU);
      #1;
      total++; if (issue_ready !== 1'b0 || commit_instr.valid !== 1'b1 || commit_instr.rd !== 5'd4)
         begin bad++; $display("FAIL b2b_full rdy=%b cv=%b rd=%0d exp 0/1/4", issue_ready, commit_instr.valid, commit_instr.rd); end
      step();
      commit_ack = 1'b0;
      #1;
      total++; if (issue_ready !== 1'b1 || issue_id !== 3'd3) begin bad++; $display("FAIL b2b_next rdy=%b id=%0d exp 1/3", issue_ready, issue_id); end
      step();
      issue_valid = 1'b0;
      #1;
      total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL b2b_refull rdy=%b exp=0", issue_ready); end
      wb_valid = 4'b1111;
      wb_id[0] = 3'd5; wb_result[0] = 32'h500;
      wb_id[1] = 3'd6; wb_result[1] = 32'h600;
      wb_id[2] = 3'd7; wb_result[2] = 32'h700;
      wb_id[3] = 3'd0; wb_result[3] = 32'h800;
      step(); clr_wb();
      commit_ack = 1'b1;
      for (int k = 0; k < 7; k++) begin
         #1;
         total++; if (commit_instr.valid !== 1'b1 || commit_instr.rd !== exp_rd[k] || commit_instr.result !== exp_res[k])
            begin bad++; $display("FAIL wrap_commit[%0d] v=%b rd=%0d res=%h exp v=1 rd=%0d res=%h", k, commit_instr.valid, commit_instr.rd, commit_instr.result, exp_rd[k], exp_res[k]); end
         step();
      end
      commit_ack = 1'b0;
      #1;
      total++; if (commit_instr.valid !== 1'b0 || commit_instr.rd !== 5'd9) begin bad++; $display("FAIL wrap_head3 v=%b rd=%0d exp v=0 rd=9", commit_instr.valid, commit_instr.rd); end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 4; k++) begin
         issue_valid = 1'b1; issue_instr = mk(5'(10 + k), FU_ALU);
         step();
      end
      flush = 1'b1; issue_instr = mk(5'd14, FU_ALU);
      wb_valid[0] = 1'b1; wb_id[0] = 3'd3; wb_result[0] = 32'h99;
      commit_ack = 1'b1;
      #1;
      total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
      step();
      flush = 1'b0; issue_valid = 1'b0; commit_ack = 1'b0; clr_wb();
      rs_addr[0] = 5'd10;
      #1;
      total++; if (sb_empty !== 1'b1 || issue_id !== 3'd0 || commit_instr.valid !== 1'b0 || rs_busy[0] !== 1'b0 || issue_ready !== 1'b1)
         begin bad++; $display("FAIL flush_state e=%b id=%0d cv=%b busy=%b rdy=%b exp 1/0/0/0/1", sb_empty, issue_id, commit_instr.valid, rs_busy[0], issue_ready); end
   endtask

   task automatic test_async_reset();
      issue_valid = 1'b1; issue_instr = mk(5'd3, FU_ALU);
      step();
      issue_instr = mk(5'd4, FU_ALU);
      step();
      issue_valid = 1'b0;
      wb_valid[0] = 1'b1; wb_id[0] = 3'd0; wb_result[0] = 32'h33;
      step(); clr_wb();
      rs_addr[0] = 5'd4;
      #1;
      total++; if (commit_instr.valid !== 1'b1 || sb_empty !== 1'b0 || rs_busy[0] !== 1'b1)
         begin bad++; $display("FAIL pre_rst cv=%b e=%b busy=%b exp 1/0/1", commit_instr.valid, sb_empty, rs_busy[0]); end
      #1;
      rst = 1'b1;
      #1;
      total++; if (sb_empty !== 1'b1 || commit_instr !== decoder_t'('0) || issue_id !== 3'd0 || rs_busy[0] !== 1'b0)
         begin bad++; $display("FAIL async_rst e=%b cv=%b id=%0d busy=%b exp 1/0/0/0", sb_empty, commit_instr.valid, issue_id, rs_busy[0]); end
      rst = 1'b0;
      rs_addr = '0;
      step();
      total++; if (issue_ready !== 1'b1 || sb_empty !== 1'b1) begin bad++; $display("FAIL post_rst rdy=%b e=%b exp 1/1", issue_ready, sb_empty); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_ooo_wb();
      test_wb_priority();
      test_raw();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
